// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb table: slot states, owner codes, tile indexing.
package bomb_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_ARMED   = 2'd1,
        SLOT_PENDING = 2'd2
    } slotState_t;

    localparam logic PLAYERA = 1'b0;
    localparam logic PLAYERB = 1'b1;

    // Row-major tile index v*(hMax+1)+h in 7-bit arithmetic.
    function automatic logic [6:0] tileIdx(input logic [3:0] h, input logic [3:0] v,
                                           input int unsigned hMax);
        logic [6:0] rowLen;
        rowLen = 7'(hMax + 1);
        return 7'(7'(v) * rowLen) + 7'(h);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb table entry: lifecycle state, fuse countdown, tile and owner.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE = 3
) (
    input  logic       clk1hz,
    input  logic       rst,
    input  logic       alloc,
    input  logic       emit,
    input  logic [3:0] allocH,
    input  logic [3:0] allocV,
    input  logic       allocOwner,
    output logic       live,
    output logic       pending,
    output logic [3:0] h,
    output logic [3:0] v,
    output logic       owner
);

    slotState_t state, stateNext;
    logic [3:0] fuse, fuseNext;

    always_ff @(posedge clk1hz) begin
        if (rst) begin
            state <= SLOT_IDLE;
            fuse  <= '0;
            h     <= '0;
            v     <= '0;
            owner <= PLAYERA;
        end else begin
            state <= stateNext;
            fuse  <= fuseNext;
            if (alloc) begin
                h     <= allocH;
                v     <= allocV;
                owner <= allocOwner;
            end
        end
    end

    always_comb begin
        stateNext = state;
        fuseNext  = fuse;
        case (state)
            SLOT_IDLE: begin
                if (alloc) begin
                    stateNext = SLOT_ARMED;
                    fuseNext  = 4'(FUSE);
                end
            end
            SLOT_ARMED: begin
                if (fuse == 4'd1) stateNext = SLOT_PENDING;
                else              fuseNext  = fuse - 4'd1;
            end
            SLOT_PENDING: begin
                if (emit) stateNext = SLOT_IDLE;
            end
            default: stateNext = SLOT_IDLE;
        endcase
    end

    assign live    = (state != SLOT_IDLE);
    assign pending = (state == SLOT_PENDING);

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb table: two-player placement arbitration, fuse timing and a
// serialized blast stream, plus a per-tile occupancy map.
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int unsigned HMAXTILE   = 9,
    parameter int unsigned VMAXTILE   = 5,
    parameter int unsigned NSLOT      = 4,
    parameter int unsigned PER_PLAYER = 2,
    parameter int unsigned FUSE       = 3
) (
    input  logic                                     clk1hz,
    input  logic                                     rst,
    input  logic                                     reqA,
    input  logic [3:0]                               posAh,
    input  logic [3:0]                               posAv,
    input  logic                                     reqB,
    input  logic [3:0]                               posBh,
    input  logic [3:0]                               posBv,
    output logic                                     grantA,
    output logic                                     grantB,
    output logic [3:0]                               bombsA,
    output logic [3:0]                               bombsB,
    output logic [(HMAXTILE+1)*(VMAXTILE+1)-1:0]     bombMap,
    output logic                                     blastValid,
    output logic [3:0]                               blastH,
    output logic [3:0]                               blastV,
    output logic                                     blastOwner
);

    localparam int unsigned MAPW  = (HMAXTILE + 1) * (VMAXTILE + 1);
    localparam logic [3:0]  HLIM  = 4'(HMAXTILE);
    localparam logic [3:0]  VLIM  = 4'(VMAXTILE);
    localparam logic [3:0]  PPLIM = 4'(PER_PLAYER);

    logic [NSLOT-1:0] alloc, emit, live, pending, slotOwner, allocOwner;
    logic [3:0]       slotH [NSLOT];
    logic [3:0]       slotV [NSLOT];
    logic [3:0]       allocH [NSLOT];
    logic [3:0]       allocV [NSLOT];

    logic             pri;
    logic [6:0]       tileA, tileB;
    logic             occA, occB, eligA, eligB, contested, winA, winB;
    logic             anyPending;
    int unsigned      firstFree, secondFree, freeCnt, slotB;

    for (genvar g = 0; g < NSLOT; g++) begin : gSlot
        bomb_slot #(.FUSE(FUSE)) uSlot (
            .clk1hz    (clk1hz),
            .rst       (rst),
            .alloc     (alloc[g]),
            .emit      (emit[g]),
            .allocH    (allocH[g]),
            .allocV    (allocV[g]),
            .allocOwner(allocOwner[g]),
            .live      (live[g]),
            .pending   (pending[g]),
            .h         (slotH[g]),
            .v         (slotV[g]),
            .owner     (slotOwner[g])
        );
    end

    always_comb begin
        bombMap = '0;
        bombsA  = '0;
        bombsB  = '0;
        for (int unsigned s = 0; s < NSLOT; s++) begin
            if (live[s]) begin
                if (slotOwner[s] == PLAYERA) bombsA = bombsA + 4'd1;
                else                         bombsB = bombsB + 4'd1;
            end
        end
        for (int unsigned t = 0; t < MAPW; t++)
            for (int unsigned s = 0; s < NSLOT; s++)
                if (live[s] && tileIdx(slotH[s], slotV[s], HMAXTILE) == 7'(t))
                    bombMap[t] = 1'b1;
    end

    // Eligibility and contention are all judged on pre-edge slot state.
    always_comb begin
        tileA = tileIdx(posAh, posAv, HMAXTILE);
        tileB = tileIdx(posBh, posBv, HMAXTILE);
        occA  = 1'b0;
        occB  = 1'b0;
        for (int unsigned t = 0; t < MAPW; t++) begin
            if (7'(t) == tileA) occA = bombMap[t];
            if (7'(t) == tileB) occB = bombMap[t];
        end

        freeCnt    = 0;
        firstFree  = 0;
        secondFree = 0;
        for (int unsigned s = 0; s < NSLOT; s++) begin
            if (!live[s]) begin
                if (freeCnt == 0)      firstFree  = s;
                else if (freeCnt == 1) secondFree = s;
                if (freeCnt < 2) freeCnt = freeCnt + 1;
            end
        end

        eligA = reqA && (posAh <= HLIM) && (posAv <= VLIM) && (bombsA < PPLIM)
                && !occA && (freeCnt != 0);
        eligB = reqB && (posBh <= HLIM) && (posBv <= VLIM) && (bombsB < PPLIM)
                && !occB && (freeCnt != 0);
        contested = eligA && eligB && ((tileA == tileB) || (freeCnt == 1));
        winA  = eligA && (!contested || (pri == PLAYERA));
        winB  = eligB && (!contested || (pri == PLAYERB));
        slotB = winA ? secondFree : firstFree;

        anyPending = 1'b0;
        for (int unsigned s = 0; s < NSLOT; s++) begin
            alloc[s]      = 1'b0;
            allocH[s]     = posAh;
            allocV[s]     = posAv;
            allocOwner[s] = PLAYERA;
            if (winA && s == firstFree) alloc[s] = 1'b1;
            if (winB && s == slotB) begin
                alloc[s]      = 1'b1;
                allocH[s]     = posBh;
                allocV[s]     = posBv;
                allocOwner[s] = PLAYERB;
            end
            emit[s]    = pending[s] && !anyPending;
            anyPending = anyPending | pending[s];
        end
    end

    always_ff @(posedge clk1hz) begin
        if (rst) begin
            pri        <= PLAYERA;
            grantA     <= 1'b0;
            grantB     <= 1'b0;
            blastValid <= 1'b0;
            blastH     <= '0;
            blastV     <= '0;
            blastOwner <= PLAYERA;
        end else begin
            grantA     <= winA;
            grantB     <= winB;
            blastValid <= anyPending;
            if (contested) pri <= ~pri;
            for (int unsigned s = 0; s < NSLOT; s++) begin
                if (emit[s]) begin
                    blastH     <= slotH[s];
                    blastV     <= slotV[s];
                    blastOwner <= slotOwner[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: a tick-based bomb list model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_bomb_scheduler;

    localparam int HMAX = 9;
    localparam int VMAX = 5;
    localparam int NSLOT = 4;
    localparam int PP = 2;
    localparam int FUSE = 3;
    localparam int MAPW = (HMAX + 1) * (VMAX + 1);

    logic            clk1hz = 1'b0;
    logic            rst, reqA, reqB;
    logic [3:0]      posAh, posAv, posBh, posBv;
    logic            grantA, grantB, blastValid, blastOwner;
    logic [3:0]      bombsA, bombsB, blastH, blastV;
    logic [MAPW-1:0] bombMap;

    int errors = 0;
    int checks = 0;

    bomb_scheduler #(.HMAXTILE(HMAX), .VMAXTILE(VMAX), .NSLOT(NSLOT),
                     .PER_PLAYER(PP), .FUSE(FUSE)) dut (
        .clk1hz(clk1hz), .rst(rst),
        .reqA(reqA), .posAh(posAh), .posAv(posAv),
        .reqB(reqB), .posBh(posBh), .posBv(posBv),
        .grantA(grantA), .grantB(grantB),
        .bombsA(bombsA), .bombsB(bombsB), .bombMap(bombMap),
        .blastValid(blastValid), .blastH(blastH), .blastV(blastV),
        .blastOwner(blastOwner)
    );

    always #5 clk1hz = ~clk1hz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each bomb remembers the tick it was placed on; it detonates on the
    // first tick after placeTick+FUSE at which no lower entry is detonating.
    typedef struct {
        bit valid;
        int h;
        int v;
        bit owner;
        int due;
    } bomb_t;

    bomb_t mb [NSLOT];
    int    tick = 0;
    bit    ready = 0;
    bit    mPri, gA, gB, okA, okB, contest;
    bit    eGA, eGB, eBlast, eO;
    int    eH, eV, emitSlot, cntA, cntB;
    int    freeQ[$];

    function automatic bit occupied(input int h, input int v);
        for (int i = 0; i < NSLOT; i++)
            if (mb[i].valid && mb[i].h == h && mb[i].v == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [MAPW-1:0] expMap();
        logic [MAPW-1:0] m = '0;
        for (int i = 0; i < NSLOT; i++)
            if (mb[i].valid) m[mb[i].v * (HMAX + 1) + mb[i].h] = 1'b1;
        return m;
    endfunction

    function automatic int expCount(input bit who);
        int c = 0;
        for (int i = 0; i < NSLOT; i++)
            if (mb[i].valid && mb[i].owner == who) c++;
        return c;
    endfunction

    always @(posedge clk1hz) begin
        tick++;
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) mb[i].valid = 1'b0;
            mPri = 0; eGA = 0; eGB = 0; eBlast = 0; eH = 0; eV = 0; eO = 0;
            ready = 1;
        end else begin
            freeQ.delete();
            for (int i = 0; i < NSLOT; i++)
                if (!mb[i].valid) freeQ.push_back(i);
            cntA = expCount(1'b0);
            cntB = expCount(1'b1);
            okA = reqA && posAh <= HMAX && posAv <= VMAX && cntA < PP
                  && !occupied(posAh, posAv) && freeQ.size() > 0;
            okB = reqB && posBh <= HMAX && posBv <= VMAX && cntB < PP
                  && !occupied(posBh, posBv) && freeQ.size() > 0;
            contest = okA && okB && ((posAh == posBh && posAv == posBv) || freeQ.size() == 1);
            gA = okA && (!contest || !mPri);
            gB = okB && (!contest || mPri);
            if (contest) mPri = !mPri;
            emitSlot = -1;
            for (int i = 0; i < NSLOT; i++)
                if (emitSlot < 0 && mb[i].valid && tick > mb[i].due) emitSlot = i;
            eBlast = (emitSlot >= 0);
            if (eBlast) begin
                eH = mb[emitSlot].h; eV = mb[emitSlot].v; eO = mb[emitSlot].owner;
                mb[emitSlot].valid = 1'b0;
            end
            if (gA) mb[freeQ.pop_front()] = '{1'b1, int'(posAh), int'(posAv), 1'b0, tick + FUSE};
            if (gB) mb[freeQ.pop_front()] = '{1'b1, int'(posBh), int'(posBv), 1'b1, tick + FUSE};
            eGA = gA;
            eGB = gB;
        end
    end

    always @(negedge clk1hz) begin
        if (ready) begin
            check("grantA", 64'(grantA), 64'(eGA));
            check("grantB", 64'(grantB), 64'(eGB));
            check("blastValid", 64'(blastValid), 64'(eBlast));
            check("blastH", 64'(blastH), 64'(eH));
            check("blastV", 64'(blastV), 64'(eV));
            check("blastOwner", 64'(blastOwner), 64'(eO));
            check("bombsA", 64'(bombsA), 64'(expCount(1'b0)));
            check("bombsB", 64'(bombsB), 64'(expCount(1'b1)));
            check("bombMap", 64'(bombMap), 64'(expMap()));
        end
    end

    task automatic cyc();
        @(negedge clk1hz);
    endtask

    initial begin
        rst = 1; reqA = 0; reqB = 0;
        posAh = 0; posAv = 0; posBh = 0; posBv = 0;
        cyc(); cyc();
        check("rst grantA", 64'(grantA), 64'd0);
        check("rst blastValid", 64'(blastValid), 64'd0);
        check("rst bombMap", 64'(bombMap), 64'd0);
        check("rst bombsA", 64'(bombsA), 64'd0);
        rst = 0;

        // out-of-range column is refused
        reqA = 1; posAh = 10; posAv = 0; cyc(); reqA = 0;
        check("oor grantA", 64'(grantA), 64'd0);

        // single bomb at (2,3)
        reqA = 1; posAh = 2; posAv = 3; cyc(); reqA = 0;
        check("single grantA", 64'(grantA), 64'd1);
        check("single map32", 64'(bombMap[32]), 64'd1);
        check("single bombsA", 64'(bombsA), 64'd1);
        repeat (3) cyc();
        check("single early blast", 64'(blastValid), 64'd0);
        check("single map32 held", 64'(bombMap[32]), 64'd1);
        cyc();
        check("single blastValid", 64'(blastValid), 64'd1);
        check("single blastH", 64'(blastH), 64'd2);
        check("single blastV", 64'(blastV), 64'd3);
        check("single owner", 64'(blastOwner), 64'd0);
        check("single map clear", 64'(bombMap), 64'd0);
        check("single bombsA 0", 64'(bombsA), 64'd0);
        repeat (2) cyc();

        // contention: A wins first, then B wins the repeat
        reqA = 1; reqB = 1; posAh = 4; posAv = 1; posBh = 4; posBv = 1; cyc();
        check("cont1 grantA", 64'(grantA), 64'd1);
        check("cont1 grantB", 64'(grantB), 64'd0);
        posAh = 5; posBh = 5; cyc(); reqA = 0; reqB = 0;
        check("cont2 grantA", 64'(grantA), 64'd0);
        check("cont2 grantB", 64'(grantB), 64'd1);
        check("cont2 bombsB", 64'(bombsB), 64'd1);
        repeat (8) cyc();

        // per-player limit
        reqA = 1; posAh = 1; posAv = 0; cyc();
        check("limit g1", 64'(grantA), 64'd1);
        posAv = 1; cyc();
        check("limit g2", 64'(grantA), 64'd1);
        posAv = 2; cyc(); reqA = 0;
        check("limit g3", 64'(grantA), 64'd0);
        check("limit bombsA", 64'(bombsA), 64'd2);
        repeat (8) cyc();

        // full table, then a held fifth request from A at (9,5)
        reqA = 1; reqB = 1; posAh = 0; posAv = 0; posBh = 0; posBv = 1; cyc();
        check("full g1A", 64'(grantA), 64'd1);
        check("full g1B", 64'(grantB), 64'd1);
        posAv = 2; posBv = 3; cyc(); reqB = 0;
        check("full g2A", 64'(grantA), 64'd1);
        check("full g2B", 64'(grantB), 64'd1);
        check("full map", 64'(bombMap), 64'h0000_0000_0000_0000 | 64'h4010_0401);
        posAh = 9; posAv = 5;
        cyc(); check("full wait1", 64'(grantA), 64'd0);
        cyc(); check("full wait2", 64'(grantA), 64'd0);
        cyc();
        check("full blast1", 64'(blastValid), 64'd1);
        check("full blast1 own", 64'(blastOwner), 64'd0);
        check("full wait3", 64'(grantA), 64'd0);
        cyc();
        check("full grant5", 64'(grantA), 64'd1);
        check("full blast2 own", 64'(blastOwner), 64'd1);
        check("full blast2 V", 64'(blastV), 64'd1);
        cyc(); check("full held1", 64'(grantA), 64'd0);
        cyc(); check("full dup", 64'(grantA), 64'd0);
        check("full blast4 V", 64'(blastV), 64'd3);
        reqA = 0;
        repeat (8) cyc();

        // serialization of simultaneous expiries
        reqA = 1; reqB = 1; posAh = 3; posAv = 3; posBh = 4; posBv = 4; cyc();
        reqA = 0; reqB = 0;
        check("ser grantA", 64'(grantA), 64'd1);
        check("ser grantB", 64'(grantB), 64'd1);
        repeat (3) cyc();
        check("ser early", 64'(blastValid), 64'd0);
        cyc();
        check("ser b1 valid", 64'(blastValid), 64'd1);
        check("ser b1 H", 64'(blastH), 64'd3);
        check("ser b1 own", 64'(blastOwner), 64'd0);
        cyc();
        check("ser b2 valid", 64'(blastValid), 64'd1);
        check("ser b2 H", 64'(blastH), 64'd4);
        check("ser b2 own", 64'(blastOwner), 64'd1);
        cyc();
        check("ser done", 64'(blastValid), 64'd0);
        repeat (2) cyc();

        // reset while three bombs are live
        reqA = 1; reqB = 1; posAh = 2; posAv = 2; posBh = 3; posBv = 2; cyc();
        reqB = 0; posAv = 4; cyc(); reqA = 0;
        check("rmid bombsA", 64'(bombsA), 64'd2);
        check("rmid bombsB", 64'(bombsB), 64'd1);
        rst = 1; cyc(); rst = 0;
        check("rmid map", 64'(bombMap), 64'd0);
        check("rmid bombsA 0", 64'(bombsA), 64'd0);
        check("rmid bombsB 0", 64'(bombsB), 64'd0);
        check("rmid grantA", 64'(grantA), 64'd0);
        repeat (6) begin
            cyc();
            check("rmid no blast", 64'(blastValid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
